// File: rtl/merge.sv
// -----------------------------------------------------------------------------
// merge -- N-to-1 master-side request arbiter.
//
// Collects native requests from N_MASTERS masters, grants one at a time,
// forwards the granted request to the single downstream split stage, and
// routes the slave response back to the granted master only.
//
// Parameters
//   N_MASTERS : number of masters (2..16)
//   REQ_W     : request slot width;  slot MSB is valid
//   RESP_W    : response slot width; slot bit 0 is ready
//   The REQ_W/RESP_W defaults describe the interconnect.vh slot layouts:
//     request  = {valid, we, addr[31:0], wdata[31:0]}  (66 bits)
//     response = {rdata[31:0], ready}                  (33 bits)
//
// Ports
//   clk    in  : system clock, rising edge
//   rst_n  in  : asynchronous active-low reset
//   m_req  in  : N_MASTERS request slots, slot i at [(i+1)*REQ_W-1 : i*REQ_W]
//   m_resp out : N_MASTERS response slots, slot i at [(i+1)*RESP_W-1 : i*RESP_W]
//   s_req  out : request forwarded to the split stage
//   s_resp in  : response from the split stage
//
// Configuration macro
//   MERGE_RR_EN : defined   -> round-robin arbitration with a rotating pointer
//                 undefined -> fixed priority, lowest-index valid master wins
// -----------------------------------------------------------------------------
module merge #(
  parameter int N_MASTERS = 2,
  parameter int REQ_W     = 66,
  parameter int RESP_W    = 33
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_MASTERS*REQ_W-1:0]  m_req,
  output logic [N_MASTERS*RESP_W-1:0] m_resp,
  output logic [REQ_W-1:0]            s_req,
  input  logic [RESP_W-1:0]           s_resp
);

  localparam int GW = $clog2(N_MASTERS);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t              state, state_next;
  logic [GW-1:0]       grant, grant_next;
  logic [GW-1:0]       base;
  logic [GW-1:0]       winner;
  logic                found;
  logic [GW:0]         cand;
  logic [N_MASTERS-1:0] valids;

  // Valid bit of every master slot.
  for (genvar i = 0; i < N_MASTERS; i++) begin : g_valid
    assign valids[i] = m_req[i*REQ_W + REQ_W - 1];
  end

`ifdef MERGE_RR_EN
  logic [GW-1:0] ptr, ptr_next;

  // Search starts at the rotating pointer.
  assign base = ptr;
`else
  // Fixed priority: search always starts at master 0.
  assign base = '0;
`endif

  // Winner search: first valid master at or above base, wrapping past the
  // top index. cand is one bit wider than an index so base+k can be folded
  // back into range with a single subtraction.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 0; k < N_MASTERS; k++) begin
      cand = {1'b0, base} + (GW+1)'(k);
      if (cand >= (GW+1)'(N_MASTERS)) begin
        cand = cand - (GW+1)'(N_MASTERS);
      end
      if (!found && valids[cand[GW-1:0]]) begin
        found  = 1'b1;
        winner = cand[GW-1:0];
      end
    end
  end

  // State register. Reset forces IDLE at once, which is what drops s_req
  // (and all responses) asynchronously when rst_n falls mid-transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
`ifdef MERGE_RR_EN
      ptr   <= '0;
`endif
    end else begin
      state <= state_next;
      grant <= grant_next;
`ifdef MERGE_RR_EN
      ptr   <= ptr_next;
`endif
    end
  end

  // Next state and outputs. In BUSY the granted slot is forwarded
  // combinationally in both directions, so a dropped valid from the owner
  // shows up on s_req and ready reaches the owner in the same cycle.
  // Requests from other masters are not looked at until the next IDLE.
  always_comb begin
    state_next = state;
    grant_next = grant;
`ifdef MERGE_RR_EN
    ptr_next   = ptr;
`endif
    s_req      = '0;
    m_resp     = '0;

    case (state)
      IDLE: begin
        // Ready seen here belongs to no transaction and is ignored.
        if (found) begin
          state_next = BUSY;
          grant_next = winner;
        end
      end
      BUSY: begin
        s_req = m_req[int'(grant)*REQ_W +: REQ_W];
        m_resp[int'(grant)*RESP_W +: RESP_W] = s_resp;
        if (s_resp[0]) begin
          state_next = IDLE;
`ifdef MERGE_RR_EN
          // Move past the master just served.
          ptr_next = (grant == GW'(N_MASTERS - 1)) ? '0 : grant + GW'(1);
`endif
        end
      end
    endcase
  end

endmodule
